// File: rtl/exmem_pkg.sv
// Shared types for the execute->memory pipeline buffer: control bundle,
// skid-buffer state encoding and the write-gating helper.
package exmem_pkg;

    typedef struct packed {
        logic       result_src;
        logic       mem_write;
        logic [1:0] mem_type;
        logic       mem_sign;
        logic       auipc;
        logic       reg_write;
        logic       jal;
    } exmem_ctrl_t;

    localparam int unsigned CTRL_W = $bits(exmem_ctrl_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    // Fields that cause architectural side effects; forced low on a bubble.
    localparam exmem_ctrl_t CTRL_GATE_MASK = '{
        result_src: 1'b0,
        mem_write:  1'b1,
        mem_type:   2'b00,
        mem_sign:   1'b0,
        auipc:      1'b0,
        reg_write:  1'b1,
        jal:        1'b0
    };

    function automatic exmem_ctrl_t gate_ctrl(input exmem_ctrl_t c, input logic v);
        exmem_ctrl_t r;
        r = v ? c : exmem_ctrl_t'(c & ~CTRL_GATE_MASK);
        return r;
    endfunction

endpackage

// File: rtl/exmem_pipe_buf_skid.sv
// Generic 2-entry skid buffer over a packed payload; the main register
// drives the output, the skid register absorbs one beat under back-pressure.
module skid_reg2
    import exmem_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_from_in;

    // Both handshake outputs come straight from the state register.
    assign o_ready   = (r_state != ST_SKID);
    assign o_valid   = (r_state != ST_EMPTY);
    assign o_data    = r_main;
    assign w_in_acc  = i_valid & o_ready;
    assign w_out_acc = o_valid & i_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_acc) begin
                        w_state_nxt    = ST_FULL;
                        w_main_from_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    case ({w_in_acc, w_out_acc})
                        2'b11: w_main_from_in = 1'b1;
                        2'b10: begin
                            w_state_nxt    = ST_SKID;
                            w_skid_from_in = 1'b1;
                        end
                        2'b01: w_state_nxt = ST_EMPTY;
                        default: w_state_nxt = ST_FULL;
                    endcase
                end
                ST_SKID: begin
                    if (w_out_acc) begin
                        w_state_nxt      = ST_FULL;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/exmem_pipe_buf.sv
// Execute->memory pipeline stage: elastic skid buffer with flush, bubble
// write-gating and a saturating stall counter. State changes on falling edge.
module exmem_pipe_buf
    import exmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  exmem_ctrl_t               ctrl_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     rd2_i,
    input  logic [DATA_WIDTH-1:0]     pc_inc_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output exmem_ctrl_t               ctrl_o,
    output logic [DATA_WIDTH-1:0]     alu_result_o,
    output logic [DATA_WIDTH-1:0]     rd2_o,
    output logic [DATA_WIDTH-1:0]     pc_inc_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic                      flush_i,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    localparam int unsigned PAY_W = CTRL_W + 3 * DATA_WIDTH + REG_ADDR_WIDTH;

    logic [PAY_W-1:0]     w_pay_in;
    logic [PAY_W-1:0]     w_pay_out;
    exmem_ctrl_t          w_ctrl_raw;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    assign w_pay_in = {ctrl_i, alu_result_i, rd2_i, pc_inc_i, rd_addr_i};

    skid_reg2 #(
        .WIDTH(PAY_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush_i),
        .i_valid (valid_i),
        .o_ready (ready_o),
        .i_data  (w_pay_in),
        .o_valid (valid_o),
        .i_ready (ready_i),
        .o_data  (w_pay_out)
    );

    assign {w_ctrl_raw, alu_result_o, rd2_o, pc_inc_o, rd_addr_o} = w_pay_out;
    assign ctrl_o = gate_ctrl(w_ctrl_raw, valid_o);

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_exmem_pipe_buf.sv
// Directed bench for exmem_pipe_buf: streaming, back-pressure, flush,
// bubble gating, async reset and stall-counter saturation (CNT_WIDTH=4).
module tb_exmem_pipe_buf;
    import exmem_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 4;

    logic          clk;
    logic          rst_n;
    logic          valid_i;
    logic          ready_o;
    exmem_ctrl_t   ctrl_i;
    logic [DW-1:0] alu_result_i;
    logic [DW-1:0] rd2_i;
    logic [DW-1:0] pc_inc_i;
    logic [AW-1:0] rd_addr_i;
    logic          valid_o;
    logic          ready_i;
    exmem_ctrl_t   ctrl_o;
    logic [DW-1:0] alu_result_o;
    logic [DW-1:0] rd2_o;
    logic [DW-1:0] pc_inc_o;
    logic [AW-1:0] rd_addr_o;
    logic          flush_i;
    logic [CW-1:0] stall_cnt_o;

    int unsigned n_checks;
    int unsigned n_fail;

    exmem_pipe_buf #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ctrl_i       (ctrl_i),
        .alu_result_i (alu_result_i),
        .rd2_i        (rd2_i),
        .pc_inc_i     (pc_inc_i),
        .rd_addr_i    (rd_addr_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .ctrl_o       (ctrl_o),
        .alu_result_o (alu_result_o),
        .rd2_o        (rd2_o),
        .pc_inc_o     (pc_inc_o),
        .rd_addr_o    (rd_addr_o),
        .flush_i      (flush_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Active edge is falling; outputs are sampled on the following rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        valid_i      = 1'b0;
        ready_i      = 1'b0;
        flush_i      = 1'b0;
        ctrl_i       = '0;
        alu_result_i = '0;
        rd2_i        = '0;
        pc_inc_i     = '0;
        rd_addr_i    = '0;

        @(posedge clk);
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_ready", 32'(ready_o), 32'd1);
        check_val("rst_stall", 32'(stall_cnt_o), 32'd0);
        check_val("rst_alu",   alu_result_o, 32'd0);
        rst_n = 1'b1;

        // Streaming at full rate
        ready_i          = 1'b1;
        valid_i          = 1'b1;
        ctrl_i.reg_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            alu_result_i = 32'(i * 16);
            tick();
            check_val("stream_alu",   alu_result_o, 32'(i * 16));
            check_val("stream_valid", 32'(valid_o), 32'd1);
            check_val("stream_ready", 32'(ready_o), 32'd1);
            check_val("stream_regw",  32'(ctrl_o.reg_write), 32'd1);
        end
        valid_i = 1'b0;
        tick();
        check_val("stream_drain", 32'(valid_o), 32'd0);
        check_val("stream_stall", 32'(stall_cnt_o), 32'd0);

        // Back-pressure into the skid entry
        ready_i      = 1'b0;
        valid_i      = 1'b1;
        alu_result_i = 32'hA;
        rd2_i        = 32'h1111_000A;
        pc_inc_i     = 32'h0000_0104;
        rd_addr_i    = 5'd5;
        tick();
        check_val("bp_first_ready", 32'(ready_o), 32'd1);
        alu_result_i = 32'hB;
        rd2_i        = 32'h2222_000B;
        pc_inc_i     = 32'h0000_0108;
        rd_addr_i    = 5'd6;
        tick();
        check_val("bp_skid_ready", 32'(ready_o), 32'd0);
        valid_i = 1'b0;
        tick();
        tick();
        check_val("bp_hold_alu",  alu_result_o, 32'hA);
        check_val("bp_hold_rd2",  rd2_o, 32'h1111_000A);
        check_val("bp_hold_pc",   pc_inc_o, 32'h0000_0104);
        check_val("bp_hold_rd",   32'(rd_addr_o), 32'd5);
        check_val("bp_stall",     32'(stall_cnt_o), 32'd3);
        ready_i = 1'b1;
        tick();
        check_val("bp_second_alu", alu_result_o, 32'hB);
        check_val("bp_second_rd",  32'(rd_addr_o), 32'd6);
        check_val("bp_second_vld", 32'(valid_o), 32'd1);
        check_val("bp_second_rdy", 32'(ready_o), 32'd1);
        tick();
        check_val("bp_empty",       32'(valid_o), 32'd0);
        check_val("bp_stall_after", 32'(stall_cnt_o), 32'd3);

        // Flush while both entries are occupied
        ready_i          = 1'b0;
        valid_i          = 1'b1;
        ctrl_i.reg_write = 1'b1;
        ctrl_i.mem_write = 1'b1;
        alu_result_i     = 32'hD;
        tick();
        alu_result_i = 32'hE;
        tick();
        check_val("fl_skid_ready", 32'(ready_o), 32'd0);
        check_val("fl_pre_memw",   32'(ctrl_o.mem_write), 32'd1);
        flush_i      = 1'b1;
        alu_result_i = 32'hC;
        tick();
        check_val("fl_valid", 32'(valid_o), 32'd0);
        check_val("fl_ready", 32'(ready_o), 32'd1);
        check_val("fl_stall", 32'(stall_cnt_o), 32'd5);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        // Bubble gating with write controls asserted at the input
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("gate_valid", 32'(valid_o), 32'd0);
            check_val("gate_regw",  32'(ctrl_o.reg_write), 32'd0);
            check_val("gate_memw",  32'(ctrl_o.mem_write), 32'd0);
        end

        // Asynchronous reset mid-stream
        ready_i      = 1'b0;
        valid_i      = 1'b1;
        alu_result_i = 32'h77;
        tick();
        tick();
        check_val("ar_pre_valid", 32'(valid_o), 32'd1);
        check_val("ar_pre_stall", 32'(stall_cnt_o), 32'd6);
        rst_n = 1'b0;
        #1;
        check_val("ar_valid", 32'(valid_o), 32'd0);
        check_val("ar_ready", 32'(ready_o), 32'd1);
        check_val("ar_regw",  32'(ctrl_o.reg_write), 32'd0);
        check_val("ar_stall", 32'(stall_cnt_o), 32'd0);
        check_val("ar_alu",   alu_result_o, 32'd0);
        @(posedge clk);
        rst_n = 1'b1;

        // Stall counter saturation
        valid_i      = 1'b1;
        alu_result_i = 32'h55;
        tick();
        check_val("sat_first_accept", alu_result_o, 32'h55);
        check_val("sat_start", 32'(stall_cnt_o), 32'd0);
        valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check_val("sat_stall", 32'(stall_cnt_o), 32'd15);
        ready_i = 1'b1;
        tick();
        check_val("sat_drain", 32'(valid_o), 32'd0);
        check_val("sat_keep",  32'(stall_cnt_o), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
